dcache_mem_bridge: RTL and testbench

Memory-side bridge directly downstream of the data-cache controller FSM. It consumes the controller's `memory_valid` / `memory_for_store` request and returns a one-cycle `memory_ready` completion. Each request becomes either a line-refill read burst or a single-word write on the external bus, and the refill is assembled into a full cache-line buffer. An optional one-entry posted write buffer lets stores complete early.

---
 rtl/dcache_mem_bridge.sv | 196 +++++++++++++++++++
 tb/tb_dcache_mem_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_bridge.sv
// Memory-side bridge for the data-cache controller: line-refill read bursts and single-word stores.
// Define DCACHE_BRIDGE_WRITE_BUF_EN to add a one-entry posted write buffer that lets stores complete early.
module dcache_mem_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memory_valid,
    input  logic                         memory_for_store,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W/8-1:0]          mem_wstrb,
    output logic                         memory_ready,
    output logic [LINE_WORDS*DATA_W-1:0] line_data,
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_rdy,
    input  logic                         ret_valid,
    input  logic [DATA_W-1:0]            ret_data,
    output logic                         wr_req,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W/8-1:0]          wr_strb,
    input  logic                         wr_rdy,
    input  logic                         wr_done
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int CNT_W  = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                memory_ready_q, memory_ready_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0]   line_data_q, line_data_d;
    logic                wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
`ifdef DCACHE_BRIDGE_WRITE_BUF_EN
    logic                buf_full_q, buf_full_d;
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rd_addr_d   = rd_addr_q;
        line_data_d = line_data_q;
        wr_req_d    = wr_req_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
`ifdef DCACHE_BRIDGE_WRITE_BUF_EN
        buf_full_d  = buf_full_q;
        // Buffer drains independently: request until accepted, then wait for the response.
        if (wr_req_q && wr_rdy) begin
            wr_req_d = 1'b0;
        end
        if (buf_full_q && !wr_req_q && wr_done) begin
            buf_full_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (memory_valid) begin
                    if (memory_for_store) begin
`ifdef DCACHE_BRIDGE_WRITE_BUF_EN
                        if (!buf_full_q) begin
                            buf_full_d = 1'b1;
                            wr_req_d   = 1'b1;
                            wr_addr_d  = mem_addr;
                            wr_data_d  = mem_wdata;
                            wr_strb_d  = mem_wstrb;
                            state_d    = DONE;
                        end
`else
                        wr_addr_d = mem_addr;
                        wr_data_d = mem_wdata;
                        wr_strb_d = mem_wstrb;
                        state_d   = WR_REQ;
`endif
                    end else begin
`ifdef DCACHE_BRIDGE_WRITE_BUF_EN
                        // Refill must not overtake a buffered store to the same memory.
                        if (!buf_full_q) begin
                            rd_addr_d = mem_addr & ~ADDR_W'(LINE_W / 8 - 1);
                            beat_d    = '0;
                            state_d   = RD_REQ;
                        end
`else
                        rd_addr_d = mem_addr & ~ADDR_W'(LINE_W / 8 - 1);
                        beat_d    = '0;
                        state_d   = RD_REQ;
`endif
                    end
                end
            end
            RD_REQ: begin
                if (rd_rdy) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (ret_valid) begin
                    line_data_d[int'(beat_q)*DATA_W +: DATA_W] = ret_data;
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == CNT_W'(LINE_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            WR_REQ: begin
                if (wr_rdy) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wr_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request/handshake outputs are registered copies of the next state.
        memory_ready_d = (state_d == DONE);
        rd_req_d       = (state_d == RD_REQ);
`ifndef DCACHE_BRIDGE_WRITE_BUF_EN
        wr_req_d       = (state_d == WR_REQ);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            memory_ready_q <= 1'b0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            line_data_q    <= '0;
            wr_req_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_strb_q      <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            memory_ready_q <= memory_ready_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            line_data_q    <= line_data_d;
            wr_req_q       <= wr_req_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            wr_strb_q      <= wr_strb_d;
        end
    end

`ifdef DCACHE_BRIDGE_WRITE_BUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign memory_ready = memory_ready_q;
    assign line_data    = line_data_q;
    assign rd_req       = rd_req_q;
    assign rd_addr      = rd_addr_q;
    assign wr_req       = wr_req_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_strb      = wr_strb_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Scoreboard bench for dcache_mem_bridge: completions are matched against queued expectations.
`timescale 1ns/1ps
module tb_dcache_mem_bridge;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_WORDS * DATA_W;
    localparam int STRB_W     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              memory_valid, memory_for_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              memory_ready;
    logic [LINE_W-1:0] line_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy, ret_valid;
    logic [DATA_W-1:0] ret_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_rdy, wr_done;

    dcache_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst(rst),
        .memory_valid(memory_valid), .memory_for_store(memory_for_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .memory_ready(memory_ready), .line_data(line_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [LINE_W-1:0] line;
    } exp_t;

    exp_t              sb_q[$];
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    logic [LINE_W-1:0] model_line;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: every memory_ready pulse consumes one expectation.
    always @(negedge clk) begin
        if (memory_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", LINE_W'(1), LINE_W'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ready_cycle", LINE_W'(cyc), LINE_W'(e.cyc));
                chk("line_data", line_data, e.line);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int lat, input logic [LINE_W-1:0] line);
        exp_t e;
        e.cyc  = cyc + lat;
        e.line = line;
        sb_q.push_back(e);
    endtask

    // Step to the completion pulse, confirm it is one cycle wide, leave in the cycle after DONE.
    task automatic wait_ready();
        int n = 0;
        while (!memory_ready && n < 40) begin
            step();
            n++;
        end
        if (!memory_ready) chk("ready_timeout", LINE_W'(0), LINE_W'(1));
        step();
        chk("ready_pulse", LINE_W'(memory_ready), LINE_W'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, LINE_W'(memory_ready), LINE_W'(0));
        chk({tag, "_rd_req"}, LINE_W'(rd_req), LINE_W'(0));
        chk({tag, "_rd_addr"}, LINE_W'(rd_addr), LINE_W'(0));
        chk({tag, "_line"}, line_data, LINE_W'(0));
        chk({tag, "_wr_req"}, LINE_W'(wr_req), LINE_W'(0));
        chk({tag, "_wr_addr"}, LINE_W'(wr_addr), LINE_W'(0));
        chk({tag, "_wr_data"}, LINE_W'(wr_data), LINE_W'(0));
        chk({tag, "_wr_strb"}, LINE_W'(wr_strb), LINE_W'(0));
    endtask

    task automatic do_refill(input logic [ADDR_W-1:0] addr, input int rdy_dly, input int stall_at,
                             input int stall_len, input logic [DATA_W-1:0] base, input int lat);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        push_exp(lat, l);
        model_line       = l;
        memory_valid     = 1'b1;
        memory_for_store = 1'b0;
        mem_addr         = addr;
        step();
        for (int i = 0; i < rdy_dly; i++) begin
            chk("rd_req_hold", LINE_W'(rd_req), LINE_W'(1));
            step();
        end
        chk("rd_req", LINE_W'(rd_req), LINE_W'(1));
        chk("rd_addr", LINE_W'(rd_addr), LINE_W'(addr & ~32'hF));
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        chk("rd_req_drop", LINE_W'(rd_req), LINE_W'(0));
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ret_valid = 1'b0;
                    step();
                end
            end
            ret_valid = 1'b1;
            ret_data  = base + DATA_W'(k);
            step();
        end
        ret_valid = 1'b0;
        wait_ready();
        memory_valid = 1'b0;
    endtask

`ifndef DCACHE_BRIDGE_WRITE_BUF_EN
    task automatic do_store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [STRB_W-1:0] strb, input int rdy_dly, input int done_dly);
        push_exp(2 + rdy_dly + done_dly, model_line);
        memory_valid     = 1'b1;
        memory_for_store = 1'b1;
        mem_addr         = addr;
        mem_wdata        = data;
        mem_wstrb        = strb;
        step();
        for (int i = 0; i < rdy_dly; i++) begin
            chk("wr_req_hold", LINE_W'(wr_req), LINE_W'(1));
            step();
        end
        chk("wr_req", LINE_W'(wr_req), LINE_W'(1));
        chk("wr_addr", LINE_W'(wr_addr), LINE_W'(addr));
        chk("wr_data", LINE_W'(wr_data), LINE_W'(data));
        chk("wr_strb", LINE_W'(wr_strb), LINE_W'(strb));
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        chk("wr_req_drop", LINE_W'(wr_req), LINE_W'(0));
        for (int i = 1; i < done_dly; i++) step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        wait_ready();
        memory_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        memory_valid = 1'b0; memory_for_store = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = '0;
        wr_rdy = 1'b0; wr_done = 1'b0;
        model_line = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Back-to-back beats, immediate acceptance.
        do_refill(32'h1000_0024, 0, LINE_WORDS, 0, 32'h0000_00A0, 6);
        // Delayed acceptance and a two-cycle gap between beats 1 and 2.
        do_refill(32'h1000_0F38, 3, 2, 2, 32'h0000_00B0, 11);

`ifndef DCACHE_BRIDGE_WRITE_BUF_EN
        do_store(32'h2000_0008, 32'hDEADBEEF, 4'hF, 0, 2);
        do_store(32'h2000_0104, 32'h1234_5678, 4'h6, 1, 1);
`else
        // Posted store followed directly by a refill that must wait for the drain.
        push_exp(1, model_line);
        memory_valid = 1'b1; memory_for_store = 1'b1;
        mem_addr = 32'h2000_0008; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
        step();
        chk("buf_wr_req", LINE_W'(wr_req), LINE_W'(1));
        chk("buf_wr_addr", LINE_W'(wr_addr), LINE_W'(32'h2000_0008));
        chk("buf_wr_data", LINE_W'(wr_data), LINE_W'(32'hDEADBEEF));
        chk("buf_wr_strb", LINE_W'(wr_strb), LINE_W'(4'hF));
        wait_ready();
        begin
            logic [LINE_W-1:0] l;
            for (int k = 0; k < LINE_WORDS; k++) l[k*DATA_W +: DATA_W] = 32'hE0 + DATA_W'(k);
            push_exp(9, l);
            model_line = l;
        end
        memory_for_store = 1'b0; mem_addr = 32'h1000_0104;
        wr_rdy = 1'b1;
        chk("raw_hold_c2", LINE_W'(rd_req), LINE_W'(0));
        step();
        wr_rdy = 1'b0;
        chk("raw_hold_c3", LINE_W'(rd_req), LINE_W'(0));
        step();
        wr_done = 1'b1;
        chk("raw_hold_c4", LINE_W'(rd_req), LINE_W'(0));
        step();
        wr_done = 1'b0;
        step();
        chk("raw_rd_req", LINE_W'(rd_req), LINE_W'(1));
        chk("raw_rd_addr", LINE_W'(rd_addr), LINE_W'(32'h1000_0100));
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            ret_valid = 1'b1;
            ret_data  = 32'hE0 + DATA_W'(k);
            step();
        end
        ret_valid = 1'b0;
        wait_ready();
        memory_valid = 1'b0;

        // Second store stalls while the first is still waiting for its response.
        push_exp(1, model_line);
        memory_valid = 1'b1; memory_for_store = 1'b1;
        mem_addr = 32'h4000_0000; mem_wdata = 32'h1111_1111; mem_wstrb = 4'h3;
        step();
        wait_ready();
        push_exp(6, model_line);
        mem_addr = 32'h4000_0004; mem_wdata = 32'h2222_2222; mem_wstrb = 4'hC;
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        chk("st2_first_drained", LINE_W'(wr_req), LINE_W'(0));
        step();
        step();
        step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        wait_ready();
        memory_valid = 1'b0;
        chk("st2_wr_req", LINE_W'(wr_req), LINE_W'(1));
        chk("st2_wr_addr", LINE_W'(wr_addr), LINE_W'(32'h4000_0004));
        chk("st2_wr_data", LINE_W'(wr_data), LINE_W'(32'h2222_2222));
        chk("st2_wr_strb", LINE_W'(wr_strb), LINE_W'(4'hC));
        wr_rdy = 1'b1;
        step();
        wr_rdy = 1'b0;
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
`endif

        // Reset in the middle of a refill, after two beats.
        memory_valid = 1'b1; memory_for_store = 1'b0; mem_addr = 32'h3000_0040;
        step();
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_data = 32'hDD0;
        step();
        ret_data = 32'hDD1;
        step();
        ret_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        memory_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int k = 2; k < LINE_WORDS; k++) begin
            ret_valid = 1'b1;
            ret_data  = 32'hDD0 + DATA_W'(k);
            step();
        end
        ret_valid = 1'b0;
        step();
        step();
        model_line = '0;
        chk("late_beats_ignored", line_data, model_line);
        do_refill(32'h3000_0040, 1, LINE_WORDS, 0, 32'h0000_00C0, 7);

        // Stray bus responses while idle leave everything untouched.
        ret_valid = 1'b1; ret_data = 32'hBAD0_BAD0; wr_done = 1'b1; rd_rdy = 1'b1;
        step();
        step();
        step();
        ret_valid = 1'b0; wr_done = 1'b0; rd_rdy = 1'b0;
        step();
        chk("idle_line_kept", line_data, model_line);
        chk("idle_rd_req", LINE_W'(rd_req), LINE_W'(0));
        chk("idle_wr_req", LINE_W'(wr_req), LINE_W'(0));

        step();
        chk("sb_empty", LINE_W'(sb_q.size()), LINE_W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
